sseg_capture: RTL
=================

# sseg_capture

Receive-side counterpart of the multiplexed seven-segment display driver: watches the active-low anode (`an`) and segment (`sseg`) lines, filters out scan transitions, and decodes each stable glyph back into a 4-bit hex value per digit. It sits in the self-check path of the display subsystem, either looped back from a display driver or on board test pins. It reports per-digit values, a per-frame completion pulse, and glitch/invalid-glyph errors.

## Interface
- `STABLE`, default 4 (legal range 2–255). Number of consecutive identical samples required before a glyph is accepted.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `an` in 4: anode enables, active-low; `an[i]=0` selects digit i.
- `sseg` in 7: segments, active-low; bit 0 = a … bit 6 = g.
- `clear` in 1: synchronous clear of captured state.
- `digits` out 16: digit i is held in `digits[4i+3:4i]`.
- `valid` out 4: `valid[i]=1` once digit i has been captured since reset or `clear`.
- `frame` out 1: one-cycle pulse when all four digits have been captured in the current frame.
- `err` out 1: one-cycle pulse per bad dwell.

## Operation
- **Sample register `r`** (11 bits, {an,sseg}) and **stability counter `cnt`**, with a `done` flag. Each cycle:
  - If the input differs from `r`: load `r`, set `cnt=0`, clear `done`.
  - Otherwise: `cnt` increments, saturating at STABLE-1.
- **Dwell evaluation** happens on the cycle where `cnt==STABLE-1` and `done==0`. That cycle sets `done=1`, and exactly one of the following applies:
  - **COMMIT**: exactly one `an` bit is low and `sseg` matches the glyph table. Write the decoded value to digit i, set `valid[i]`, and set `seen[i]`.
  - **ERR**: more than one `an` bit is low, or `sseg` is neither in the table nor blank (7'h7F). Pulse `err`; no digit change.
  - **IGNORE**: `an`=4'hF, or `sseg`=7'h7F with one anode low. No action.
- **Glyph table** (sseg hex → value): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
- **Frame tracking** uses a 4-bit `seen` mask. When a COMMIT makes `(seen | 1<<i)==4'hF`:
  - `frame` pulses that cycle.
  - `seen` is cleared to 0.
- Re-committing an already-seen digit within a frame overwrites the value and does not pulse `frame`.
- **`clear`** zeroes `digits`, `valid`, `seen`, `cnt`, and `done`, and loads `r` with the current input. It wins over a same-cycle COMMIT or ERR: no `frame` and no `err` that cycle.
- **Reset values:**
  - `digits`=16'h0000, `valid`=4'h0, `frame`=0, `err`=0.
  - `r`=11'h7FF, `cnt`=0, `done`=0, `seen`=0.

## Timing
- Inputs are sampled on the rising edge with no extra synchronizer; the design assumes `an`/`sseg` are synchronous to `clk`.
- Evaluation latency: input changes before edge k and is held. `cnt` reaches STABLE-1 at edge k+STABLE-1. `digits`/`valid`/`frame`/`err` update at edge k+STABLE.
- Any input change before edge k+STABLE-1 restarts the count, so glitches shorter than STABLE cycles are invisible.
- A dwell longer than STABLE cycles produces exactly one evaluation (`done` blocks repeats).
- `frame` and `err` are registered, one-cycle pulses and are never asserted together.
- Reset deassertion mid-dwell: counting starts fresh from the first sampled value.

## Configuration
- **`SSEG_CAPTURE_GHOST_EN`** (macro name).
  - **Defined:** after a COMMIT on digit i, a further COMMIT on the same digit i with a *different* value inside the same dwell sequence, with no other anode dwell between them, pulses `err`. This flags ghosting where segments change without an anode change. The digit is still updated.
  - **Undefined:** such a value change is a normal COMMIT with no `err`, and the tracking logic is absent.

## Test plan
- Reset, then drive an=E, sseg=40 for 10 cycles → at edge 4: `digits[3:0]`=0, `valid`=0001, `err`=0, no `frame`.
- Scan an=E/D/B/7 with sseg=79/24/30/19 at 6 cycles each → `digits`=16'h4321, `valid`=F, `frame` pulses once on the digit-3 commit edge.
- A 3-cycle glitch on sseg (STABLE=4) between dwells → no commit, no `err`, `digits` unchanged.
- an=C (two anodes) held 5 cycles → one `err` pulse at edge 4, `digits` unchanged. sseg=7'h55 on an=E → one `err` pulse.
- `clear` asserted on the same edge as the fourth commit → `digits`=0, `valid`=0, no `frame`. Async `rst` low mid-dwell → all outputs return to reset values immediately.
- With `SSEG_CAPTURE_GHOST_EN` defined: an=E, sseg 79 for 5 cycles, then sseg 24 for 5 cycles → `digits[3:0]`=2 and `err` pulses once. With it undefined: `digits[3:0]`=2, `err`=0.

Source files
------------

// File: rtl/sseg_capture.sv
// sseg_capture: decodes a scanned active-low seven-segment bus back into per-digit hex values
// Ports: clk; rst (async, active-low); an[3:0], sseg[6:0] observed display lines (active-low);
//   clear sync clear of captured state; digits[15:0] nibble per digit; valid[3:0] per-digit captured;
//   frame one-cycle pulse when all four digits are captured; err one-cycle pulse per bad dwell.
// Optional: define SSEG_CAPTURE_GHOST_EN to flag a value change on one anode with no other anode dwell between.
module sseg_capture #(
  parameter int STABLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [3:0]  valid,
  output logic        frame,
  output logic        err
);
  localparam logic [7:0] CNT_MAX = 8'(STABLE - 1);
  logic [10:0] r_q, r_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d, seen_q, seen_d;
  logic        frame_q, frame_d, err_q, err_d;
  logic [3:0]  r_an, val, bit_i;
  logic [6:0]  r_seg;
  logic [1:0]  idx;
  logic        hit, one_hot, eval, commit;
`ifdef SSEG_CAPTURE_GHOST_EN
  logic        gh_on_q, gh_on_d;
  logic [3:0]  gh_an_q, gh_an_d, gh_val_q, gh_val_d;
`endif

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h10;
      7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;
      7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;
      7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;
      7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;
      7'h10: decode = 5'h19;
      7'h08: decode = 5'h1A;
      7'h03: decode = 5'h1B;
      7'h46: decode = 5'h1C;
      7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;
      7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    r_an = r_q[10:7];
    r_seg = r_q[6:0];
    {hit, val} = decode(r_seg);
    idx = !r_an[0] ? 2'd0 : !r_an[1] ? 2'd1 : !r_an[2] ? 2'd2 : 2'd3;
    bit_i = 4'b0001 << idx;
    one_hot = r_an inside {4'hE, 4'hD, 4'hB, 4'h7};
    // evaluation looks at the held sample, so it still fires on the edge the input moves on
    eval = cnt_q == CNT_MAX && !done_q;
    commit = eval && one_hot && hit;
    r_d = {an, sseg};
    cnt_d = '0;
    done_d = 1'b0;
    if ({an, sseg} == r_q) begin
      r_d = r_q;
      cnt_d = cnt_q == CNT_MAX ? cnt_q : cnt_q + 8'd1;
      done_d = done_q | eval;
    end
    digits_d = digits_q;
    valid_d = valid_q;
    seen_d = seen_q;
    frame_d = 1'b0;
    err_d = eval && r_an != 4'hF && (!one_hot || (!hit && r_seg != 7'h7F));
    if (commit) begin
      digits_d[{idx, 2'b00} +: 4] = val;
      valid_d = valid_q | bit_i;
      frame_d = (seen_q | bit_i) == 4'hF;
      seen_d = frame_d ? 4'h0 : seen_q | bit_i;
    end
`ifdef SSEG_CAPTURE_GHOST_EN
    gh_on_d = gh_on_q;
    gh_an_d = gh_an_q;
    gh_val_d = gh_val_q;
    // a commit can never complete a frame here, since its digit was already seen
    if (commit && gh_on_q && gh_an_q == r_an && gh_val_q != val) err_d = 1'b1;
    if (eval) gh_on_d = commit || (gh_on_q && gh_an_q == r_an);
    if (commit) begin
      gh_an_d = r_an;
      gh_val_d = val;
    end
`endif
    if (clear) begin
      r_d = {an, sseg};
      cnt_d = '0;
      done_d = 1'b0;
      digits_d = '0;
      valid_d = '0;
      seen_d = '0;
      frame_d = 1'b0;
      err_d = 1'b0;
`ifdef SSEG_CAPTURE_GHOST_EN
      gh_on_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 11'h7FF;
      cnt_q <= '0;
      done_q <= 1'b0;
      digits_q <= '0;
      valid_q <= '0;
      seen_q <= '0;
      frame_q <= 1'b0;
      err_q <= 1'b0;
`ifdef SSEG_CAPTURE_GHOST_EN
      gh_on_q <= 1'b0;
      gh_an_q <= 4'hF;
      gh_val_q <= '0;
`endif
    end else begin
      r_q <= r_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      digits_q <= digits_d;
      valid_q <= valid_d;
      seen_q <= seen_d;
      frame_q <= frame_d;
      err_q <= err_d;
`ifdef SSEG_CAPTURE_GHOST_EN
      gh_on_q <= gh_on_d;
      gh_an_q <= gh_an_d;
      gh_val_q <= gh_val_d;
`endif
    end
  end

  assign digits = digits_q;
  assign valid = valid_q;
  assign frame = frame_q;
  assign err = err_q;
endmodule
